ctrl_count_block: RTL

//  Writer/sequencer for the block-count register: steps the interpolation datapath through
//  NUM_BLOCKS blocks per frame run. Drives the register's WRITE_EN/DATA_IN (COUNT_WE/COUNT_OUT)
//  and reads its DATA_OUT back (COUNT_IN). Issues one BLK_START per block, waits for BLK_DONE,

---
 rtl/ctrl_count_block_if.sv | 42 ++++
 rtl/ctrl_count_block.sv | 110 +++++++++++
 2 files changed

// File: rtl/ctrl_count_block_if.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_count_block_if
//  Description : Handshake/bus bundle between the block-count sequencer, the
//                interpolation datapath and the block-count register.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ctrl_count_block_if;
    logic       START;      // run request
    logic       BLK_DONE;   // datapath finished current block
    logic [3:0] COUNT_IN;   // signed read-back of the block-count register
    logic       COUNT_WE;   // block-count register write enable
    logic [3:0] COUNT_OUT;  // signed write data to the block-count register
    logic       BLK_START;  // one-cycle block kick
    logic       BUSY;       // run in progress
    logic       DONE;       // one-cycle end-of-run pulse

    // Sequencer side
    modport master (
        input  START,
        input  BLK_DONE,
        input  COUNT_IN,
        output COUNT_WE,
        output COUNT_OUT,
        output BLK_START,
        output BUSY,
        output DONE
    );

    // Environment side (datapath, register, run requester)
    modport slave (
        output START,
        output BLK_DONE,
        output COUNT_IN,
        input  COUNT_WE,
        input  COUNT_OUT,
        input  BLK_START,
        input  BUSY,
        input  DONE
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_count_block.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_count_block
//  Description : Block-count sequencer. Clears the block-count register, then
//                for each block issues BLK_START, waits for BLK_DONE and
//                writes back count+1, pulsing DONE after the last block.
//                Moore machine; every output is a register updated together
//                with the state, so outputs always reflect the current state.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_count_block #(
    parameter int NUM_BLOCKS = 8    // 1..8, count register is signed 4-bit
) (
    input  wire                        CLK,
    input  wire                        RST_SYNC_N,
    ctrl_count_block_if.master         bus
);

    // Index of the last block; register values at or above this end the run,
    // which also covers a corrupted register holding a too-large value.
    localparam logic signed [3:0] c_last_idx = 4'(NUM_BLOCKS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_INCR   = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t     r_state;
    logic       r_count_we;
    logic [3:0] r_count_out;
    logic       r_blk_start;
    logic       r_busy;
    logic       r_done;

    wire        w_is_last = ($signed(bus.COUNT_IN) >= c_last_idx);

    // State and registered Moore outputs; outputs are loaded with the decode
    // of the state being entered, so they line up with r_state exactly.
    always_ff @(posedge CLK) begin
        if (!RST_SYNC_N) begin
            r_state     <= S_IDLE;
            r_count_we  <= 1'b0;
            r_count_out <= 4'd0;
            r_blk_start <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_count_we  <= 1'b0;
            r_count_out <= 4'd0;
            r_blk_start <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.START) begin
                        r_state    <= S_CLEAR;
                        r_count_we <= 1'b1;
                    end else begin
                        r_busy     <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    r_state     <= S_ISSUE;
                    r_blk_start <= 1'b1;
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.BLK_DONE) begin
                        if (w_is_last) begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            // Register is untouched until this write, so the
                            // value read here is the one INCR would see.
                            r_state     <= S_INCR;
                            r_count_we  <= 1'b1;
                            r_count_out <= bus.COUNT_IN + 4'd1;
                        end
                    end
                end
                S_INCR: begin
                    r_state     <= S_ISSUE;
                    r_blk_start <= 1'b1;
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.COUNT_WE  = r_count_we;
    assign bus.COUNT_OUT = r_count_out;
    assign bus.BLK_START = r_blk_start;
    assign bus.BUSY      = r_busy;
    assign bus.DONE      = r_done;

endmodule
`default_nettype wire
